// File: rtl/sfp_ctrl.sv
// sfp_ctrl -- psum accumulation sequencer for one layer.
// For every kernel position it pops N_OUT OFIFO rows and does a read/write
// pass over the psum SRAM: the first position seeds each row (passthrough),
// later positions accumulate. An optional ReLU pass then rewrites every row
// before done is pulsed.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   start               one-cycle layer start (honoured only when idle)
//   relu_en             final ReLU pass enable, latched with start
//   ofifo_valid         an OFIFO row is available
//   ofifo_rd            OFIFO pop (data valid the next cycle)
//   sram_cen/sram_wen   psum SRAM enables, active-low (wen=1 is a read)
//   sram_addr           psum SRAM row
//   sfp_accum           sfp adds psum + ofifo
//   sfp_passthrough     sfp forwards ofifo only
//   sfp_actFunc         sfp activation select, tied to 2'b00
//   kij_cnt             current kernel position
//   busy, done          status; done pulses for one cycle at layer end
//
// state     | meaning
// S_IDLE    | waiting for start
// S_ACC_RD  | pop OFIFO row and read psum row (stalls while ofifo_valid=0)
// S_ACC_WR  | write seeded/accumulated psum row
// S_RELU_RD | read psum row for ReLU
// S_RELU_WR | write ReLU result
// S_DONE    | one-cycle completion pulse
module sfp_ctrl #(
  parameter int N_KIJ   = 9,
  parameter int N_OUT   = 16,
  parameter int addr_bw = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               relu_en,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [addr_bw-1:0] sram_addr,
  output logic               sfp_accum,
  output logic               sfp_passthrough,
  output logic [1:0]         sfp_actFunc,
  output logic [3:0]         kij_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC_RD, S_ACC_WR, S_RELU_RD, S_RELU_WR, S_DONE
  } state_t;

  localparam logic [addr_bw-1:0] ADDR_LAST = addr_bw'(N_OUT - 1);
  localparam logic [3:0]         KIJ_LAST  = 4'(N_KIJ - 1);

  state_t             r_state;
  logic [addr_bw-1:0] r_addr;
  logic [3:0]         r_kij;
  logic               r_relu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_kij   <= '0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACC_RD;
            r_addr  <= '0;
            r_kij   <= '0;
            r_relu  <= relu_en;
          end
        end
        S_ACC_RD: begin
          if (ofifo_valid) r_state <= S_ACC_WR;
        end
        S_ACC_WR: begin
          if (r_addr != ADDR_LAST) begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_ACC_RD;
          end else begin
            r_addr <= '0;
            if (r_kij != KIJ_LAST) begin
              r_kij   <= r_kij + 4'd1;
              r_state <= S_ACC_RD;
            end else begin
              r_state <= r_relu ? S_RELU_RD : S_DONE;
            end
          end
        end
        S_RELU_RD: r_state <= S_RELU_WR;
        S_RELU_WR: begin
          if (r_addr != ADDR_LAST) begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_RELU_RD;
          end else begin
            r_addr  <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are a pure decode of registered state; the only input in the
  // decode is ofifo_valid, which gates the pop and read in ACC_RD.
  always_comb begin
    ofifo_rd        = 1'b0;
    sram_cen        = 1'b1;
    sram_wen        = 1'b1;
    sfp_accum       = 1'b0;
    sfp_passthrough = 1'b0;
    done            = 1'b0;
    case (r_state)
      S_ACC_RD: begin
        ofifo_rd = ofifo_valid;
        sram_cen = ~ofifo_valid;
      end
      S_ACC_WR: begin
        sram_cen        = 1'b0;
        sram_wen        = 1'b0;
        sfp_passthrough = (r_kij == 4'd0);
        sfp_accum       = (r_kij != 4'd0);
      end
      S_RELU_RD: sram_cen = 1'b0;
      S_RELU_WR: begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign sram_addr   = r_addr;
  assign kij_cnt     = r_kij;
  assign sfp_actFunc = 2'b00;
  assign busy        = (r_state != S_IDLE);

endmodule
